// File: rtl/vmem_scan.sv
// vmem_scan: CPU-written 8x8 row memory driving a row-scanned LED matrix.
// Define VMEM_DBUF_EN for front/back row banks that exchange at the frame wrap.
module vmem_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] mem_addr,
  input  logic        vmem_we,
  input  logic [7:0]  vmem_din,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_data,
  output logic        frame_tick,
  output logic        swap_pending
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] BLANK_N  = 16'(BLANK_CYCLES);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t      state, state_next;
  logic [15:0] presc, presc_next;
  logic [2:0]  row, row_next;
  logic        presc_wrap, frame_wrap;
  logic        row_wr;
  logic [7:0]  front_row;
  logic [7:0]  col_next;
  logic        unused_addr;

  assign unused_addr = ^mem_addr[15:4];

  assign presc_wrap = (presc == DIV_LAST);
  assign presc_next = presc_wrap ? 16'd0 : presc + 16'd1;
  assign row_next   = presc_wrap ? row + 3'd1 : row;
  assign frame_wrap = presc_wrap && (row == 3'd7);
  assign row_wr     = vmem_we && !mem_addr[3];

  // Scan FSM: the BLANK->SHOW transition is the latch point, so the byte is
  // taken from the registers before any write landing on the same edge.
  always_ff @(posedge clock) begin
    if (reset) state <= BLANK;
    else       state <= state_next;
  end

  always_comb begin
    state_next = BLANK;
    col_next   = 8'h00;
    if (presc_next >= BLANK_N) begin
      state_next = SHOW;
      col_next   = (state == BLANK) ? front_row : col_data;
    end
  end

  // Counters and registered outputs, all aligned to the post-edge scan position.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc      <= 16'd0;
      row        <= 3'd0;
      row_sel    <= 8'h01;
      col_data   <= 8'h00;
      frame_tick <= 1'b1;
    end else begin
      presc      <= presc_next;
      row        <= row_next;
      row_sel    <= 8'h01 << row_next;
      col_data   <= col_next;
      frame_tick <= (presc_next == 16'd0) && (row_next == 3'd0);
    end
  end

`ifdef VMEM_DBUF_EN
  logic [7:0] bank [2][8];
  logic       bank_sel;
  logic       swap_req;

  assign swap_req  = vmem_we && mem_addr[3] && vmem_din[0];
  assign front_row = bank[bank_sel][row];

  // CPU always writes the back bank; a pending swap is honoured at the frame wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        bank[0][i] <= 8'h00;
        bank[1][i] <= 8'h00;
      end
      bank_sel     <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      if (row_wr) bank[~bank_sel][mem_addr[2:0]] <= vmem_din;
      if (frame_wrap && swap_pending) begin
        bank_sel     <= ~bank_sel;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end
`else
  logic [7:0] rows [8];

  assign front_row    = rows[row];
  assign swap_pending = 1'b0;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rows[i] <= 8'h00;
    end else if (row_wr) begin
      rows[mem_addr[2:0]] <= vmem_din;
    end
  end

  logic unused_frame;
  assign unused_frame = frame_wrap;
`endif

endmodule

// File: tb/tb_vmem_scan.sv
// Bench for vmem_scan (SCAN_DIV=4, BLANK_CYCLES=1): time-based reference model
// checked every cycle, plus directed writes with hand-computed literal expectations.
module tb_vmem_scan;
  localparam int SD = 4;
  localparam int B  = 1;
`ifdef VMEM_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_addr = 16'h0000;
  logic        vmem_we = 1'b0;
  logic [7:0]  vmem_din = 8'h00;
  logic [7:0]  row_sel, col_data;
  logic        frame_tick, swap_pending;

  vmem_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(B)) dut (
    .clock(clock), .reset(reset), .mem_addr(mem_addr), .vmem_we(vmem_we),
    .vmem_din(vmem_din), .row_sel(row_sel), .col_data(col_data),
    .frame_tick(frame_tick), .swap_pending(swap_pending)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: t = cycles since reset release; scan position follows from t.
  int         t = 0;
  bit         valid = 1'b0;
  logic [7:0] mb [2][8];
  logic [7:0] shown;
  bit         msel, pend;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0d", nm, act, exp, t);
    end
  endtask

  always @(posedge clock) begin
    if (reset) begin
      t = 0; shown = 8'h00; msel = 1'b0; pend = 1'b0; valid = 1'b1;
      for (int i = 0; i < 8; i++) begin mb[0][i] = 8'h00; mb[1][i] = 8'h00; end
    end else if (valid) begin
      int p, r;
      p = t % SD;
      r = (t / SD) % 8;
      if (p == B - 1) shown = mb[msel][r];
      if (vmem_we && !mem_addr[3]) mb[DBUF ? !msel : msel][mem_addr[2:0]] = vmem_din;
      if (DBUF) begin
        if (p == SD - 1 && r == 7 && pend) begin msel = !msel; pend = 1'b0; end
        else if (vmem_we && mem_addr[3] && vmem_din[0]) pend = 1'b1;
      end
      t++;
    end
  end

  always @(negedge clock) begin
    if (valid) begin
      int p, r;
      p = t % SD;
      r = (t / SD) % 8;
      chk("m_row_sel", row_sel, 8'h01 << r);
      chk("m_col_data", col_data, (p < B) ? 8'h00 : shown);
      chk("m_frame_tick", {7'b0, frame_tick}, {7'b0, (t % (8 * SD)) == 0});
      chk("m_swap_pending", {7'b0, swap_pending}, {7'b0, pend});
    end
  end

  task automatic goto(input int n);
    int k = 0;
    @(negedge clock);
    while (t != n && k < 2000) begin @(negedge clock); k++; end
    total++;
    if (t != n) begin bad++; $display("FAIL goto got=%0d want=%0d", t, n); end
  endtask

  task automatic wr(input int n, input logic [15:0] a, input logic [7:0] d);
    goto(n);
    vmem_we = 1'b1; mem_addr = a; vmem_din = d;
    @(posedge clock); #1;
    vmem_we = 1'b0; mem_addr = 16'h0000; vmem_din = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    goto(0);
    chk("c0_row_sel", row_sel, 8'h01);
    chk("c0_col", col_data, 8'h00);
    chk("c0_tick", {7'b0, frame_tick}, 8'h01);
    chk("c0_swap", {7'b0, swap_pending}, 8'h00);
    for (int c = 1; c <= 3; c++) begin
      goto(c);
      chk("c1_3_col", col_data, 8'h00);
    end
    goto(4);
    chk("c4_row_sel", row_sel, 8'h02);
    chk("c4_tick", {7'b0, frame_tick}, 8'h00);
`ifndef VMEM_DBUF_EN
    wr(6, 16'h0003, 8'hA5);
    goto(13); chk("r3_rowsel", row_sel, 8'h08); chk("r3_a5", col_data, 8'hA5);
    goto(15); chk("r3_a5_end", col_data, 8'hA5);
    wr(20, 16'hFFF3, 8'h5A);
    goto(44); chk("r3_blank", col_data, 8'h00);
    goto(45); chk("r3_hi_addr", col_data, 8'h5A);
    wr(50, 16'h0002, 8'h11);
    wr(72, 16'h0002, 8'h3C);
    goto(73); chk("r2_old", col_data, 8'h11);
    goto(105); chk("r2_new", col_data, 8'h3C);
    wr(106, 16'h0002, 8'h77);
    goto(107); chk("r2_hold", col_data, 8'h3C);
    goto(127); chk("r7_rowsel", row_sel, 8'h80);
    goto(128); chk("wrap_rowsel", row_sel, 8'h01); chk("wrap_tick", {7'b0, frame_tick}, 8'h01);
    goto(137); chk("r2_77", col_data, 8'h77);
    wr(140, 16'h000A, 8'hFF);
    wr(150, 16'h0005, 8'hC3);
    goto(169); chk("bit3_ignored", col_data, 8'h77);
    goto(182); chk("r5_rowsel", row_sel, 8'h20); chk("r5_c3", col_data, 8'hC3);
    reset = 1'b1; vmem_we = 1'b1; mem_addr = 16'h0005; vmem_din = 8'hEE;
    @(negedge clock);
    chk("rst_rowsel", row_sel, 8'h01);
    chk("rst_col", col_data, 8'h00);
    chk("rst_swap", {7'b0, swap_pending}, 8'h00);
    vmem_we = 1'b0; mem_addr = 16'h0000; vmem_din = 8'h00;
    @(posedge clock); #1 reset = 1'b0;
    goto(0);
    chk("rel_rowsel", row_sel, 8'h01); chk("rel_col", col_data, 8'h00);
    chk("rel_tick", {7'b0, frame_tick}, 8'h01);
    goto(13); chk("rel_r3", col_data, 8'h00);
    goto(21); chk("rel_r5", col_data, 8'h00);
`else
    wr(6, 16'h0000, 8'hFF);
    wr(8, 16'h0008, 8'h01);
    goto(9);  chk("db_pend", {7'b0, swap_pending}, 8'h01);
    goto(31); chk("db_pend_hold", {7'b0, swap_pending}, 8'h01);
    goto(32); chk("db_swapped", {7'b0, swap_pending}, 8'h00);
    goto(33); chk("db_front_ff", col_data, 8'hFF);
    wr(63, 16'h0008, 8'h01);
    goto(64); chk("db_wrap_req", {7'b0, swap_pending}, 8'h01);
    wr(70, 16'h0008, 8'h01);
    goto(95); chk("db_pend2", {7'b0, swap_pending}, 8'h01);
    goto(96); chk("db_swap2", {7'b0, swap_pending}, 8'h00);
    goto(97); chk("db_front_00", col_data, 8'h00);
    goto(129); chk("db_no_extra", col_data, 8'h00);
`endif
    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vmem_scan.md
VMEM_SCAN -- requirements
Module: vmem_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clock cycles per displayed row; legal range 2..65535.
REQ-002 SHALL have parameter BLANK_CYCLES, default 2: anti-ghost blank cycles at the start of each row; legal range 1..SCAN_DIV-1.
REQ-003 SHALL have port clock, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high.
REQ-005 SHALL have port mem_addr, input, 16: CPU address; only bits [3:0] are decoded, bits [15:4] are ignored.
REQ-006 SHALL have port vmem_we, input, 1: CPU video-memory write strobe, one write per cycle while high.
REQ-007 SHALL have port vmem_din, input, 8: CPU write data, sourced from the CPU register-file b operand.
REQ-008 SHALL have port row_sel, output, 8: one-hot active-high LED-matrix row drive.
REQ-009 SHALL have port col_data, output, 8: active-high column drive for the selected row.
REQ-010 SHALL have port frame_tick, output, 1: one-cycle pulse at each frame start.
REQ-011 SHALL have port swap_pending, output, 1: buffer-swap request outstanding.

Function
REQ-012 SHALL act as the responder to CPU video-memory writes: 8 x 8-bit row registers, one per matrix row.
REQ-013 SHALL write vmem_din into row mem_addr[2:0] in the cycle vmem_we=1 and mem_addr[3]=0, with no wait states and no back-pressure.
REQ-014 SHALL register all outputs.
REQ-015 SHALL use a 16-bit prescaler counting 0..SCAN_DIV-1 and a 3-bit row counter that advances, wrapping 7->0, when the prescaler wraps.
REQ-016 SHALL implement a two-state FSM per row:
- BLANK while prescaler < BLANK_CYCLES: col_data=0.
- SHOW for the remainder of the row: col_data = latched row byte.
REQ-017 SHALL latch the row byte in the last BLANK cycle from the pre-write register contents, so a write in that same cycle appears only on the next scan of that row.
REQ-018 SHALL not change the held col_data of the active row when that row is written during SHOW.
REQ-019 SHALL drive row_sel = 1 << row counter, changing in the same cycle the row counter changes.
REQ-020 SHALL pulse frame_tick high for exactly the first cycle of row 0.
REQ-021 SHALL silently ignore writes with mem_addr[3]=1 when VMEM_DBUF_EN is undefined.
REQ-022 SHALL make a frame, with default parameters, last exactly 8 x SCAN_DIV cycles.

Reset
REQ-023 SHALL, while reset=1, clear all row registers and latches to 0, set prescaler=0, row counter=0, FSM=BLANK, swap_pending=0 and bank select=0.
REQ-024 SHALL, in the first cycle after reset deasserts, drive row_sel=8'h01, col_data=8'h00 and frame_tick=1.
REQ-025 SHALL give reset priority over vmem_we, so a write in a reset cycle is lost.
REQ-026 SHALL, when reset is asserted mid-row or mid-swap, abort the row and the swap and restart per REQ-023/REQ-024.

Configuration
REQ-027 SHALL, with macro VMEM_DBUF_EN defined, instantiate two banks of 8 row registers, a front bank (displayed) and a back bank (CPU-written), with:
- a write with mem_addr[3]=1 and vmem_din[0]=1 setting swap_pending;
- the banks exchanging and swap_pending clearing at the next row 7->0 wrap;
- a request while swap_pending=1 having no effect;
- a request in the wrap cycle itself taking effect at the following wrap.
REQ-028 SHALL, without VMEM_DBUF_EN, use a single bank, tie swap_pending to 0 and behave per REQ-021.

Verification
REQ-029 SHALL cover (SCAN_DIV=4, BLANK_CYCLES=1): release reset -> cycle0 row_sel=01 col=00 frame_tick=1; cycles1-3 col=00; cycle4 row_sel=02.
REQ-030 SHALL cover: write 8'hA5 to addr 0x0003 before frame start -> row_sel=08 SHOW cycles show col=A5; addr 0xFFF3 gives the same result.
REQ-031 SHALL cover: write row 2 = 8'h3C in the latch cycle of row 2 -> old value shown this frame, 3C shown the next frame.
REQ-032 SHALL cover: 32 continuous cycles -> frame_tick pulses exactly every 32 cycles; row_sel visits 01..80 in order and wraps to 01.
REQ-033 SHALL cover (VMEM_DBUF_EN): write back row 0 = 8'hFF, write addr 0x0008 data 01 -> swap_pending=1; front row 0 stays 00 until the wrap, then shows FF and swap_pending=0.
REQ-034 SHALL cover: reset asserted during the row 5 SHOW phase -> next cycle matches REQ-023; after release, behaviour matches REQ-024 with all rows reading 00.
